// File: rtl/blk_f0cc2a_pkg.sv
// Shared definitions for the on-chip debug memory controller.
//   state_t : controller FSM states
//   op_t    : JTAG operation held in the pending register
//   JDO_*   : bit positions of the fields carried on the 38-bit jdo word
package blk_f0cc2a_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_JT_RD  = 2'd1,
    ST_AV_RD  = 2'd2,
    ST_AV_ACK = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'd0,
    OP_READ  = 2'd1,
    OP_WRITE = 2'd2
  } op_t;

  localparam int JDO_W         = 38;
  localparam int JDO_WDATA_LSB = 3;
  localparam int JDO_ADDR_LSB  = 26;
  localparam int JDO_AUTORD    = 35;

endpackage

// File: rtl/de2_115_camera_nios2_gen2_0_cpu_debug_ocimem_ram.sv
// Single-port synchronous debug RAM, one cycle read latency, per-byte writes.
// Contents are never reset.
//   clk   : clock
//   addr  : word address
//   we    : write strobe (qualified per byte by be)
//   be    : byte enables
//   wdata : write data
//   q     : read data, registered, for the address presented the cycle before
module de2_115_camera_nios2_gen2_0_cpu_debug_ocimem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic [ADDR_W-1:0]     addr,
  input  logic                  we,
  input  logic [DATA_W/8-1:0]   be,
  input  logic [DATA_W-1:0]     wdata,
  output logic [DATA_W-1:0]     q
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NB; i++) begin
      if (we && be[i]) begin
        mem[addr][i*8 +: 8] <= wdata[i*8 +: 8];
      end
    end
    q <= mem[addr];
  end

endmodule

// File: rtl/blk_f0cc2a.sv
// On-chip debug memory controller. Serves JTAG ocimem operations (decoded
// from jdo plus take_* pulses) and Avalon debug-slave accesses onto one
// single-port RAM, JTAG having priority.
//   clk, reset                 : clock, synchronous active-high reset
//   jdo, take_*                : JTAG operation word and action pulses
//   address..debugaccess       : Avalon debug-slave request
//   readdata, waitrequest      : Avalon response
//   MonDReg                    : last JTAG read result
//   jtag_busy, jtag_overrun    : JTAG op in flight / sticky dropped-pulse flag
//   fsm_state, mon_a_reg       : debug view of the FSM state and JTAG address
//
// Avalon handshake: the master holds read or write with address/data stable
// until it samples waitrequest low at a clock edge; that edge completes the
// transfer. waitrequest is high in every state except AV_ACK.
module blk_f0cc2a
  import blk_f0cc2a_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [JDO_W-1:0]    jdo,
  input  logic                take_action_ocimem_a,
  input  logic                take_no_action_ocimem_a,
  input  logic                take_action_ocimem_b,
  input  logic [ADDR_W-1:0]   address,
  input  logic [3:0]          byteenable,
  input  logic                read,
  input  logic                write,
  input  logic [DATA_W-1:0]   writedata,
  input  logic                debugaccess,
  output logic [DATA_W-1:0]   readdata,
  output logic                waitrequest,
  output logic [DATA_W-1:0]   MonDReg,
  output logic                jtag_busy,
  output logic                jtag_overrun,
  output state_t              fsm_state,
  output logic [ADDR_W-1:0]   mon_a_reg
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   mon_a, mon_a_nxt;

  logic                pend_valid;
  op_t                 pend_op;
  logic [ADDR_W-1:0]   pend_addr;
  logic                pend_autord;
  logic [DATA_W-1:0]   pend_wdata;

  logic                take_any, take_multi, busy, clr_pend;
  op_t                 take_op;
  logic                mon_d_ld, rd_ld;

  logic [ADDR_W-1:0]   ram_addr;
  logic                ram_we;
  logic [3:0]          ram_be;
  logic [DATA_W-1:0]   ram_wdata, ram_q;

  // jdo bits outside the address/data/autoread fields carry nothing here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_AUTORD+1], jdo[JDO_WDATA_LSB-1:0]};

  assign take_any   = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign take_multi = (take_action_ocimem_b & take_action_ocimem_a)
                    | (take_action_ocimem_b & take_no_action_ocimem_a)
                    | (take_action_ocimem_a & take_no_action_ocimem_a);
  assign take_op    = take_action_ocimem_b ? OP_WRITE :
                      take_action_ocimem_a ? OP_LOAD  : OP_READ;

  assign busy         = pend_valid | (state == ST_JT_RD);
  assign jtag_busy    = busy;
  assign waitrequest  = (state != ST_AV_ACK);
  assign fsm_state    = state;
  assign mon_a_reg    = mon_a;

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_IDLE;
      mon_a        <= '0;
      MonDReg      <= '0;
      readdata     <= '0;
      pend_valid   <= 1'b0;
      pend_op      <= OP_LOAD;
      pend_addr    <= '0;
      pend_autord  <= 1'b0;
      pend_wdata   <= '0;
      jtag_overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      mon_a <= mon_a_nxt;
      if (mon_d_ld) MonDReg  <= ram_q;
      if (rd_ld)    readdata <= ram_q;
      // A clear only happens while busy, and a capture only while not busy,
      // so the two never collide.
      if (take_any && !busy) begin
        pend_valid  <= 1'b1;
        pend_op     <= take_op;
        pend_addr   <= jdo[JDO_ADDR_LSB +: ADDR_W];
        pend_autord <= jdo[JDO_AUTORD];
        pend_wdata  <= jdo[JDO_WDATA_LSB +: DATA_W];
      end else if (clr_pend) begin
        pend_valid  <= 1'b0;
      end
      if (take_any && (busy || take_multi)) jtag_overrun <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    mon_a_nxt = mon_a;
    ram_addr  = mon_a;
    ram_we    = 1'b0;
    ram_be    = 4'hF;
    ram_wdata = pend_wdata;
    clr_pend  = 1'b0;
    mon_d_ld  = 1'b0;
    rd_ld     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pend_valid) begin
          case (pend_op)
            OP_LOAD: begin
              mon_a_nxt = pend_addr;
              ram_addr  = pend_addr;
              if (pend_autord) state_nxt = ST_JT_RD;
              else             clr_pend  = 1'b1;
            end
            OP_READ: begin
              mon_a_nxt = mon_a + ADDR_W'(1);
              state_nxt = ST_JT_RD;
            end
            OP_WRITE: begin
              ram_we    = 1'b1;
              mon_a_nxt = mon_a + ADDR_W'(1);
              clr_pend  = 1'b1;
            end
            default: clr_pend = 1'b1;
          endcase
        end else if (!take_any) begin
          // A pulse arriving this cycle already outranks the Avalon master.
          if (read) begin
            ram_addr  = address;
            state_nxt = ST_AV_RD;
          end else if (write) begin
            ram_addr  = address;
            ram_we    = debugaccess;
            ram_be    = byteenable;
            ram_wdata = writedata;
            state_nxt = ST_AV_ACK;
          end
        end
      end
      ST_JT_RD: begin
        mon_d_ld  = 1'b1;
        clr_pend  = 1'b1;
        state_nxt = ST_IDLE;
      end
      ST_AV_RD: begin
        rd_ld     = 1'b1;
        state_nxt = ST_AV_ACK;
      end
      ST_AV_ACK: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  de2_115_camera_nios2_gen2_0_cpu_debug_ocimem_ram #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_ram (
    .clk   (clk),
    .addr  (ram_addr),
    .we    (ram_we),
    .be    (ram_be),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_blk_f0cc2a.sv
// Directed, table-driven bench for blk_f0cc2a: JTAG and Avalon vectors from
// a table, then hand-written sequences for contention, overrun and reset.
module tb_blk_f0cc2a;
  import blk_f0cc2a_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_a = 1'b0, take_na = 1'b0, take_b = 1'b0;
  logic [7:0]  address = '0;
  logic [3:0]  byteenable = '0;
  logic        read = 1'b0, write = 1'b0, debugaccess = 1'b0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata, MonDReg;
  logic        waitrequest, jtag_busy, jtag_overrun;
  state_t      fsm_state;
  logic [7:0]  mon_a_reg;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  logic [31:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  blk_f0cc2a dut (
    .clk(clk), .reset(reset), .jdo(jdo),
    .take_action_ocimem_a(take_a), .take_no_action_ocimem_a(take_na),
    .take_action_ocimem_b(take_b),
    .address(address), .byteenable(byteenable), .read(read), .write(write),
    .writedata(writedata), .debugaccess(debugaccess),
    .readdata(readdata), .waitrequest(waitrequest), .MonDReg(MonDReg),
    .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .fsm_state(fsm_state), .mon_a_reg(mon_a_reg)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    else pass_cnt++;
  endtask

  function automatic logic [37:0] jdo_load(input logic [7:0] a, input logic ar);
    logic [37:0] j;
    j = '0;
    j[33:26] = a;
    j[35] = ar;
    return j;
  endfunction

  function automatic logic [37:0] jdo_write(input logic [31:0] d);
    logic [37:0] j;
    j = '0;
    j[34:3] = d;
    return j;
  endfunction

  // ---------------- drivers ----------------
  typedef enum {K_LOAD, K_READ, K_WRITE, K_AVW, K_AVR} kind_e;

  // One take_* pulse, then count cycles until jtag_busy drops.
  task automatic jt_op(input kind_e k, input logic [37:0] j, output int lat);
    jdo     = j;
    take_a  = (k == K_LOAD);
    take_na = (k == K_READ);
    take_b  = (k == K_WRITE);
    tick();
    take_a = 1'b0; take_na = 1'b0; take_b = 1'b0;
    lat = 0;
    while (jtag_busy && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  // Avalon access held until waitrequest low; lat = cycle (1-based) in which
  // waitrequest is seen low. Optionally fires a take_b pulse in cycle 1.
  task automatic av_op(input logic is_rd, input logic [7:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic dbg,
                       input logic pulse_b, input logic [37:0] pj, output int lat);
    address = a; writedata = d; byteenable = be; debugaccess = dbg;
    read = is_rd; write = !is_rd;
    if (pulse_b) begin
      jdo = pj;
      take_b = 1'b1;
    end
    lat = 1;
    while (waitrequest && lat < 20) begin
      tick();
      take_b = 1'b0;
      lat++;
    end
    tick();
    read = 1'b0; write = 1'b0; take_b = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    kind_e       kind;
    logic [7:0]  addr;
    logic        autord;
    logic [31:0] data;
    logic [3:0]  be;
    logic        dbg;
    int          exp_lat;
    logic [7:0]  exp_mon_a;
    logic [31:0] exp_val;   // MonDReg for JTAG ops, readdata for Avalon reads
  } vec_t;

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    int lat;
    logic [37:0] j;
    logic [31:0] wexp;

    vecs[0]  = '{K_AVW,  8'h20, 1'b0, 32'hAAAAAAAA, 4'hF, 1'b1, 2, 8'h00, 32'h0};
    vecs[1]  = '{K_AVW,  8'h20, 1'b0, 32'h12345678, 4'h3, 1'b1, 2, 8'h00, 32'h0};
    vecs[2]  = '{K_AVR,  8'h20, 1'b0, 32'h0,        4'hF, 1'b1, 3, 8'h00, 32'hAAAA5678};
    vecs[3]  = '{K_AVW,  8'h20, 1'b0, 32'h00000000, 4'hF, 1'b0, 2, 8'h00, 32'h0};
    vecs[4]  = '{K_AVR,  8'h20, 1'b0, 32'h0,        4'hF, 1'b0, 3, 8'h00, 32'hAAAA5678};
    vecs[5]  = '{K_LOAD, 8'h10, 1'b0, 32'h0,        4'hF, 1'b0, 1, 8'h10, 32'h0};
    vecs[6]  = '{K_WRITE,8'h00, 1'b0, 32'hDEADBEEF, 4'hF, 1'b0, 1, 8'h11, 32'h0};
    vecs[7]  = '{K_AVR,  8'h10, 1'b0, 32'h0,        4'hF, 1'b1, 3, 8'h00, 32'hDEADBEEF};
    vecs[8]  = '{K_LOAD, 8'h10, 1'b1, 32'h0,        4'hF, 1'b0, 2, 8'h10, 32'hDEADBEEF};
    vecs[9]  = '{K_READ, 8'h00, 1'b0, 32'h0,        4'hF, 1'b0, 2, 8'h11, 32'hDEADBEEF};
    vecs[10] = '{K_AVW,  8'hFF, 1'b0, 32'h0F0F0F0F, 4'hF, 1'b1, 2, 8'h00, 32'h0};
    vecs[11] = '{K_AVW,  8'h00, 1'b0, 32'h00C0FFEE, 4'hF, 1'b1, 2, 8'h00, 32'h0};
    vecs[12] = '{K_LOAD, 8'hFF, 1'b0, 32'h0,        4'hF, 1'b0, 1, 8'hFF, 32'hDEADBEEF};
    vecs[13] = '{K_READ, 8'h00, 1'b0, 32'h0,        4'hF, 1'b0, 2, 8'h00, 32'h0F0F0F0F};
    vecs[14] = '{K_READ, 8'h00, 1'b0, 32'h0,        4'hF, 1'b0, 2, 8'h01, 32'h00C0FFEE};
    vecs[15] = '{K_AVW,  8'h30, 1'b0, 32'h00000000, 4'hF, 1'b1, 2, 8'h00, 32'h0};
    vecs[16] = '{K_AVW,  8'h31, 1'b0, 32'h00000000, 4'hF, 1'b1, 2, 8'h00, 32'h0};
    vecs[17] = '{K_LOAD, 8'h30, 1'b0, 32'h0,        4'hF, 1'b0, 1, 8'h30, 32'h00C0FFEE};

    // ---- reset state ----
    tick(); tick(); tick();
    check("rst_readdata", readdata, 32'h0);
    check("rst_waitrequest", 32'(waitrequest), 32'h1);
    check("rst_mondreg", MonDReg, 32'h0);
    check("rst_busy", 32'(jtag_busy), 32'h0);
    check("rst_overrun", 32'(jtag_overrun), 32'h0);
    check("rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("rst_mon_a", 32'(mon_a_reg), 32'h0);
    reset = 1'b0;
    tick();

    // ---- table ----
    for (int i = 0; i < NV; i++) begin
      case (vecs[i].kind)
        K_AVW: begin
          av_op(1'b0, vecs[i].addr, vecs[i].data, vecs[i].be, vecs[i].dbg, 1'b0, '0, lat);
          check($sformatf("v%0d_wr_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
        end
        K_AVR: begin
          exp_q.push_back(vecs[i].exp_val);
          av_op(1'b1, vecs[i].addr, 32'h0, 4'hF, vecs[i].dbg, 1'b0, '0, lat);
          check($sformatf("v%0d_rd_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
          check($sformatf("v%0d_rd_data", i), readdata, exp_q.pop_front());
        end
        default: begin
          j = (vecs[i].kind == K_WRITE) ? jdo_write(vecs[i].data)
                                        : jdo_load(vecs[i].addr, vecs[i].autord);
          jt_op(vecs[i].kind, j, lat);
          check($sformatf("v%0d_jt_lat", i), 32'(lat), 32'(vecs[i].exp_lat));
          check($sformatf("v%0d_mon_a", i), 32'(mon_a_reg), 32'(vecs[i].exp_mon_a));
          check($sformatf("v%0d_mondreg", i), MonDReg, vecs[i].exp_val);
        end
      endcase
      tick();
    end
    check("table_no_overrun", 32'(jtag_overrun), 32'h0);

    // ---- JTAG write pending when Avalon read of the same word arrives ----
    jdo = jdo_write(32'h00000055);
    take_b = 1'b1;
    tick();
    take_b = 1'b0;
    av_op(1'b1, 8'h30, 32'h0, 4'hF, 1'b0, 1'b0, '0, lat);
    check("cont_pend_lat", 32'(lat), 32'd4);
    check("cont_pend_data", readdata, 32'h00000055);
    check("cont_pend_mon_a", 32'(mon_a_reg), 32'h31);
    tick();

    // ---- JTAG write pulse in the same cycle as the Avalon read ----
    av_op(1'b1, 8'h31, 32'h0, 4'hF, 1'b0, 1'b1, jdo_write(32'h00000066), lat);
    check("cont_same_done", 32'(lat < 20), 32'h1);
    check("cont_same_data", readdata, 32'h00000066);
    check("cont_same_mon_a", 32'(mon_a_reg), 32'h32);
    tick();

    // ---- second pulse while an autoread LOAD is in service ----
    jdo = jdo_load(8'h10, 1'b1);
    take_a = 1'b1;
    tick();
    take_a = 1'b0;
    take_na = 1'b1;
    tick();
    take_na = 1'b0;
    lat = 0;
    while (jtag_busy && lat < 20) begin
      tick();
      lat++;
    end
    check("ovr_flag", 32'(jtag_overrun), 32'h1);
    check("ovr_mondreg", MonDReg, 32'hDEADBEEF);
    check("ovr_mon_a", 32'(mon_a_reg), 32'h10);
    tick();

    // ---- reset while in AV_RD ----
    address = 8'h20; read = 1'b1;
    tick();
    check("mid_state_avrd", 32'(fsm_state), 32'(ST_AV_RD));
    reset = 1'b1;
    tick();
    reset = 1'b0; read = 1'b0;
    check("mid_rst_state", 32'(fsm_state), 32'(ST_IDLE));
    check("mid_rst_waitreq", 32'(waitrequest), 32'h1);
    check("mid_rst_mondreg", MonDReg, 32'h0);
    check("mid_rst_overrun", 32'(jtag_overrun), 32'h0);
    check("mid_rst_mon_a", 32'(mon_a_reg), 32'h0);
    tick();

    // ---- simultaneous take_a and take_b: write wins, overrun set ----
    j = jdo_load(8'h40, 1'b0) | jdo_write(32'h00000077);
    wexp = j[34:3];
    jdo = j;
    take_a = 1'b1; take_b = 1'b1;
    tick();
    take_a = 1'b0; take_b = 1'b0;
    lat = 0;
    while (jtag_busy && lat < 20) begin
      tick();
      lat++;
    end
    check("multi_overrun", 32'(jtag_overrun), 32'h1);
    check("multi_mon_a", 32'(mon_a_reg), 32'h01);
    tick();
    exp_q.push_back(wexp);
    av_op(1'b1, 8'h00, 32'h0, 4'hF, 1'b0, 1'b0, '0, lat);
    check("multi_rd_lat", 32'(lat), 32'd3);
    check("multi_rd_data", readdata, exp_q.pop_front());

    // ---- report ----
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
